ats21_cmd_sequencer: RTL and testbench

- Front-end controller between two software clients (A, B) and the ATS21 timer core.
- Accepts one 32-bit command per client over a valid/ready handshake.
- Resolves same-target conflicts with round-robin arbitration instead of letting the core Nack both.
- Drives the core's req/ready two-beat 16-bit transfer, captures per-lane Ack/Nack and returns one response per granted command.

---
 rtl/ats21_cmd_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_ats21_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ats21_cmd_sequencer.sv
// Two-client command front end for the ATS21 timer core: round-robin arbitration of
// same-target commands, two-beat 16-bit transfer, per-lane Ack/Nack response.
module ats21_cmd_sequencer #(
    parameter int RDY_TIMEOUT = 16,
    parameter int STAT_LAT    = 3,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_cmd_valid,
    input  logic [31:0] a_cmd_data,
    output logic        a_cmd_ready,
    output logic        a_rsp_valid,
    output logic        a_rsp_ack,
    output logic        a_rsp_err,
    input  logic        b_cmd_valid,
    input  logic [31:0] b_cmd_data,
    output logic        b_cmd_ready,
    output logic        b_rsp_valid,
    output logic        b_rsp_ack,
    output logic        b_rsp_err,
    output logic        ats_req,
    input  logic        ats_ready,
    output logic [15:0] ats_ctrlA,
    output logic [15:0] ats_ctrlB,
    input  logic        ats_statA,
    input  logic        ats_statB,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RDY,
        HI,
        LO,
        STAT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_CLK,
        CLS_ALM,
        CLS_MODE
    } cls_t;

    function automatic cls_t cmd_class(input logic [31:0] cmd);
        cls_t cls;
        case (cmd[31:29])
            3'b001, 3'b010:         cls = CLS_CLK;
            3'b101, 3'b110, 3'b111: cls = CLS_ALM;
            3'b011:                 cls = CLS_MODE;
            default:                cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    // Two commands collide when they address the same clock, the same alarm, or both the mode register.
    function automatic logic cmd_conflict(input logic [31:0] cmd_a, input logic [31:0] cmd_b);
        cls_t cls_a;
        cls_t cls_b;
        logic hit;
        cls_a = cmd_class(cmd_a);
        cls_b = cmd_class(cmd_b);
        hit   = 1'b0;
        if (cls_a == cls_b) begin
            case (cls_a)
                CLS_CLK:  hit = (cmd_a[28:25] == cmd_b[28:25]);
                CLS_ALM:  hit = (cmd_a[28:24] == cmd_b[28:24]);
                CLS_MODE: hit = 1'b1;
                default:  hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               rr_ptr, rr_nxt;
    logic [31:0]        cmd_a_q, cmd_a_nxt;
    logic [31:0]        cmd_b_q, cmd_b_nxt;
    logic               gnt_a, gnt_a_nxt;
    logic               gnt_b, gnt_b_nxt;

    logic               a_cmd_ready_nxt, a_rsp_valid_nxt, a_rsp_ack_nxt, a_rsp_err_nxt;
    logic               b_cmd_ready_nxt, b_rsp_valid_nxt, b_rsp_ack_nxt, b_rsp_err_nxt;
    logic               ats_req_nxt;
    logic [15:0]        ats_ctrlA_nxt, ats_ctrlB_nxt;
    logic               busy_nxt;

    logic               conflict;
    logic               take_a, take_b;

    // rr_ptr = 0 favours lane A, 1 favours lane B
    assign conflict = a_cmd_valid && b_cmd_valid && cmd_conflict(a_cmd_data, b_cmd_data);
    assign take_a   = a_cmd_valid && (!conflict || !rr_ptr);
    assign take_b   = b_cmd_valid && (!conflict ||  rr_ptr);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        rr_nxt          = rr_ptr;
        cmd_a_nxt       = cmd_a_q;
        cmd_b_nxt       = cmd_b_q;
        gnt_a_nxt       = gnt_a;
        gnt_b_nxt       = gnt_b;
        a_cmd_ready_nxt = 1'b0;
        a_rsp_valid_nxt = 1'b0;
        a_rsp_ack_nxt   = 1'b0;
        a_rsp_err_nxt   = 1'b0;
        b_cmd_ready_nxt = 1'b0;
        b_rsp_valid_nxt = 1'b0;
        b_rsp_ack_nxt   = 1'b0;
        b_rsp_err_nxt   = 1'b0;
        ats_req_nxt     = 1'b0;
        ats_ctrlA_nxt   = 16'h0000;
        ats_ctrlB_nxt   = 16'h0000;

        case (state)
            IDLE: begin
                if (a_cmd_valid || b_cmd_valid) begin
                    gnt_a_nxt       = take_a;
                    gnt_b_nxt       = take_b;
                    cmd_a_nxt       = take_a ? a_cmd_data : 32'h0000_0000;
                    cmd_b_nxt       = take_b ? b_cmd_data : 32'h0000_0000;
                    a_cmd_ready_nxt = take_a;
                    b_cmd_ready_nxt = take_b;
                    if (conflict) begin
                        rr_nxt = ~rr_ptr;
                    end
                    ats_req_nxt = 1'b1;
                    state_nxt   = REQ;
                end
            end

            REQ: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_RDY;
            end

            WAIT_RDY: begin
                if (ats_ready) begin
                    ats_ctrlA_nxt = cmd_a_q[31:16];
                    ats_ctrlB_nxt = cmd_b_q[31:16];
                    state_nxt     = HI;
                end else if (cnt == CNT_W'(RDY_TIMEOUT - 1)) begin
                    // Core never answered: abort and report an error on every granted lane.
                    a_rsp_valid_nxt = gnt_a;
                    a_rsp_err_nxt   = gnt_a;
                    b_rsp_valid_nxt = gnt_b;
                    b_rsp_err_nxt   = gnt_b;
                    state_nxt       = RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            HI: begin
                ats_ctrlA_nxt = cmd_a_q[15:0];
                ats_ctrlB_nxt = cmd_b_q[15:0];
                state_nxt     = LO;
            end

            LO: begin
                cnt_nxt   = '0;
                state_nxt = STAT;
            end

            STAT: begin
                if (cnt == CNT_W'(STAT_LAT)) begin
                    a_rsp_valid_nxt = gnt_a;
                    a_rsp_ack_nxt   = gnt_a & ats_statA;
                    b_rsp_valid_nxt = gnt_b;
                    b_rsp_ack_nxt   = gnt_b & ats_statB;
                    state_nxt       = RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            RESP: begin
                gnt_a_nxt = 1'b0;
                gnt_b_nxt = 1'b0;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // Every output is a flop loaded from the next-state decode, so it lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= 1'b0;
            cmd_a_q     <= 32'h0000_0000;
            cmd_b_q     <= 32'h0000_0000;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            a_cmd_ready <= 1'b0;
            a_rsp_valid <= 1'b0;
            a_rsp_ack   <= 1'b0;
            a_rsp_err   <= 1'b0;
            b_cmd_ready <= 1'b0;
            b_rsp_valid <= 1'b0;
            b_rsp_ack   <= 1'b0;
            b_rsp_err   <= 1'b0;
            ats_req     <= 1'b0;
            ats_ctrlA   <= 16'h0000;
            ats_ctrlB   <= 16'h0000;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rr_ptr      <= rr_nxt;
            cmd_a_q     <= cmd_a_nxt;
            cmd_b_q     <= cmd_b_nxt;
            gnt_a       <= gnt_a_nxt;
            gnt_b       <= gnt_b_nxt;
            a_cmd_ready <= a_cmd_ready_nxt;
            a_rsp_valid <= a_rsp_valid_nxt;
            a_rsp_ack   <= a_rsp_ack_nxt;
            a_rsp_err   <= a_rsp_err_nxt;
            b_cmd_ready <= b_cmd_ready_nxt;
            b_rsp_valid <= b_rsp_valid_nxt;
            b_rsp_ack   <= b_rsp_ack_nxt;
            b_rsp_err   <= b_rsp_err_nxt;
            ats_req     <= ats_req_nxt;
            ats_ctrlA   <= ats_ctrlA_nxt;
            ats_ctrlB   <= ats_ctrlB_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ats21_cmd_sequencer.sv
// Scoreboard bench for ats21_cmd_sequencer: directed commands push expected beats and
// responses; a core model and a response monitor pop and compare independently.
module tb_ats21_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_cmd_valid, b_cmd_valid;
    logic [31:0] a_cmd_data, b_cmd_data;
    logic        a_cmd_ready, a_rsp_valid, a_rsp_ack, a_rsp_err;
    logic        b_cmd_ready, b_rsp_valid, b_rsp_ack, b_rsp_err;
    logic        ats_req, ats_ready, ats_statA, ats_statB, busy;
    logic [15:0] ats_ctrlA, ats_ctrlB;

    ats21_cmd_sequencer #(.RDY_TIMEOUT(16), .STAT_LAT(3), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .a_cmd_valid(a_cmd_valid), .a_cmd_data(a_cmd_data), .a_cmd_ready(a_cmd_ready),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ack(a_rsp_ack), .a_rsp_err(a_rsp_err),
        .b_cmd_valid(b_cmd_valid), .b_cmd_data(b_cmd_data), .b_cmd_ready(b_cmd_ready),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ack(b_rsp_ack), .b_rsp_err(b_rsp_err),
        .ats_req(ats_req), .ats_ready(ats_ready), .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
        .ats_statA(ats_statA), .ats_statB(ats_statB), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ack;
        logic       err;
        logic [7:0] lat;
    } rsp_t;

    rsp_t        exp_a[$];
    rsp_t        exp_b[$];
    logic [63:0] exp_beat[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_a = 0;
    int          rdy_b = 0;
    bit          core_rdy_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Core model: answers each request with a one-cycle ready, then captures both beats.
    initial begin : core_model
        logic [63:0] got;
        ats_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (ats_req && core_rdy_en) begin
                @(posedge clk);
                #1 ats_ready = 1'b1;
                @(posedge clk);
                #1 ats_ready = 1'b0;
                @(negedge clk);
                got[63:32] = {ats_ctrlA, ats_ctrlB};
                @(negedge clk);
                got[31:0] = {ats_ctrlA, ats_ctrlB};
                if (exp_beat.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL beats: got transfer %h, required none", got);
                end else begin
                    chk("beats", got, exp_beat.pop_front());
                end
            end
        end
    end

    // Response monitor: latency is measured from that lane's own cmd_ready pulse.
    always @(negedge clk) begin : rsp_monitor
        rsp_t e;
        if (a_cmd_ready) rdy_a = cyc;
        if (b_cmd_ready) rdy_b = cyc;
        if (a_rsp_valid) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_rsp: got response ack=%b err=%b, required none", a_rsp_ack, a_rsp_err);
            end else begin
                e = exp_a.pop_front();
                chk("a_rsp {ack,err,lat}", {a_rsp_ack, a_rsp_err, 8'(cyc - rdy_a)}, 64'(e));
            end
        end
        if (b_rsp_valid) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_rsp: got response ack=%b err=%b, required none", b_rsp_ack, b_rsp_err);
            end else begin
                e = exp_b.pop_front();
                chk("b_rsp {ack,err,lat}", {b_rsp_ack, b_rsp_err, 8'(cyc - rdy_b)}, 64'(e));
            end
        end
    end

    task automatic push_rsp(input bit lane_b, input logic ack, input logic err, input int lat);
        rsp_t r;
        r = {ack, err, 8'(lat)};
        if (lane_b) exp_b.push_back(r);
        else exp_a.push_back(r);
    endtask

    // Presents commands and drops each valid the cycle its cmd_ready is seen.
    task automatic send(input bit ua, input bit ub, input logic [31:0] da, input logic [31:0] db,
                        output int ca, output int cb);
        bit a_done, b_done;
        int n;
        n = 0;
        ca = -1;
        cb = -1;
        a_cmd_valid = ua;
        a_cmd_data  = ua ? da : 32'h0;
        b_cmd_valid = ub;
        b_cmd_data  = ub ? db : 32'h0;
        a_done = !ua;
        b_done = !ub;
        while (!(a_done && b_done) && n < 300) begin
            @(negedge clk);
            n++;
            if (!a_done && a_cmd_ready) begin
                a_done = 1'b1;
                ca = cyc;
                a_cmd_valid = 1'b0;
                a_cmd_data  = $urandom;
            end
            if (!b_done && b_cmd_ready) begin
                b_done = 1'b1;
                cb = cyc;
                b_cmd_valid = 1'b0;
                b_cmd_data  = $urandom;
            end
        end
        if (!(a_done && b_done)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send: got no cmd_ready within 300 cycles, required a=%b b=%b", ua, ub);
            a_cmd_valid = 1'b0;
            b_cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_a.size() != 0 || exp_b.size() != 0 || exp_beat.size() != 0) && n < 300);
        chk({name, " drained"}, 64'(n >= 300), 64'(0));
    endtask

    // Both lanes valid with conflicting targets: the winner goes first, the loser one transaction later.
    task automatic conflict(input string name, input logic [31:0] da, input logic [31:0] db, input bit b_first);
        int ca, cb;
        logic [63:0] ba, bb;
        ba = {da[31:16], 16'h0000, da[15:0], 16'h0000};
        bb = {16'h0000, db[31:16], 16'h0000, db[15:0]};
        if (b_first) begin
            exp_beat.push_back(bb);
            exp_beat.push_back(ba);
        end else begin
            exp_beat.push_back(ba);
            exp_beat.push_back(bb);
        end
        push_rsp(1'b0, ats_statA, 1'b0, 8);
        push_rsp(1'b1, ats_statB, 1'b0, 8);
        send(1'b1, 1'b1, da, db, ca, cb);
        chk({name, " first lane is B"}, 64'(cb < ca), 64'(b_first));
        chk({name, " grant spacing"}, 64'(b_first ? ca - cb : cb - ca), 64'(10));
        wait_idle(name);
    endtask

    initial begin : stimulus
        int ca, cb;
        reset       = 1'b1;
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        a_cmd_data  = 32'h0;
        b_cmd_data  = 32'h0;
        ats_statA   = 1'b0;
        ats_statB   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset flags", {a_cmd_ready, a_rsp_valid, a_rsp_ack, a_rsp_err, b_cmd_ready,
                            b_rsp_valid, b_rsp_ack, b_rsp_err, ats_req, busy}, 64'(0));
        chk("reset ctrl", {ats_ctrlA, ats_ctrlB}, 64'(0));
        reset = 1'b0;

        // A only: set clock 1 to 5
        ats_statA = 1'b1;
        ats_statB = 1'b0;
        exp_beat.push_back({16'h2200, 16'h0000, 16'h0005, 16'h0000});
        push_rsp(1'b0, 1'b1, 1'b0, 8);
        send(1'b1, 1'b0, 32'h2200_0005, 32'h0, ca, cb);
        wait_idle("a only");

        // Different alarms: one shared transaction, per-lane status
        exp_beat.push_back({16'hA300, 16'hA400, 16'h0010, 16'h0020});
        push_rsp(1'b0, 1'b1, 1'b0, 8);
        push_rsp(1'b1, 1'b0, 1'b0, 8);
        send(1'b1, 1'b1, 32'hA300_0010, 32'hA400_0020, ca, cb);
        chk("alarms same-cycle ready", 64'(ca - cb), 64'(0));
        wait_idle("alarms");

        // Same clock three times: A, B, A
        ats_statB = 1'b1;
        conflict("clk #1", 32'h2200_0000, 32'h2200_0000, 1'b0);
        conflict("clk #2", 32'h2200_0000, 32'h2200_0000, 1'b1);
        conflict("clk #3", 32'h2200_0000, 32'h2200_0000, 1'b0);
        // Alarm 3 via different alarm opcodes, then mode register
        ats_statA = 1'b0;
        conflict("alm", 32'hA300_0001, 32'hE300_0002, 1'b1);
        ats_statA = 1'b1;
        conflict("mode", 32'h6000_0001, 32'h7F00_0002, 1'b0);

        // Core never ready: timeout abort with err, ack forced low
        core_rdy_en = 1'b0;
        push_rsp(1'b0, 1'b0, 1'b1, 17);
        send(1'b1, 1'b0, 32'h2400_0009, 32'h0, ca, cb);
        wait_idle("timeout");
        core_rdy_en = 1'b1;

        // Reset while in STAT: no response, outputs cleared, arbitration pointer back to A
        exp_beat.push_back({16'h2200, 16'h0000, 16'h0007, 16'h0000});
        send(1'b1, 1'b0, 32'h2200_0007, 32'h0, ca, cb);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid-reset flags", {a_cmd_ready, a_rsp_valid, a_rsp_ack, a_rsp_err, b_cmd_ready,
                                b_rsp_valid, b_rsp_ack, b_rsp_err, ats_req, busy}, 64'(0));
        chk("mid-reset ctrl", {ats_ctrlA, ats_ctrlB}, 64'(0));
        chk("pre-reset beats consumed", 64'(exp_beat.size()), 64'(0));
        reset = 1'b0;
        repeat (12) @(negedge clk);
        conflict("post-reset", 32'h2200_0000, 32'h2200_0000, 1'b0);

        chk("leftover expectations", 64'(exp_a.size() + exp_b.size() + exp_beat.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
